inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; this polarity and synchronicity are fixed.
REQ-004 stall  input  StallBus  pipeline stall vector; bit0 holds the PC, bit1 holds the IF/ID boundary.
REQ-005 br_bus  input  BR_WD  {br_e, br_addr[31:0]} redirect from decode.
REQ-006 inst_sram_req  output  1  fetch request.
REQ-007 inst_sram_addr  output  32  fetch address.
REQ-008 inst_sram_addr_ok  input  1  request accepted.
REQ-009 inst_sram_data_ok  input  1  read data valid.
REQ-010 inst_sram_rdata  input  32  read data.
REQ-011 if_to_id_bus  output  IF_TO_ID_WD  {ce, pc[31:0]} toward decode.
REQ-012 inst  output  32  instruction paired with if_to_id_bus.
REQ-013 stallreq  output  1  fetch outstanding; the pipeline SHALL freeze while it is high.

Function
REQ-014 The FSM SHALL have four states: IDLE, REQ, WAIT and HOLD.
REQ-015 IDLE SHALL hold req=0 and ce=0, and SHALL go to REQ on the first clk after reset release, with fetch_pc=RESET_PC.
REQ-016 REQ SHALL drive req=1 and addr=fetch_pc; it SHALL go to WAIT on addr_ok; req SHALL drop in the cycle after addr_ok.
REQ-017 WAIT SHALL drive req=0; on data_ok it SHALL capture rdata into a one-entry buffer with fetch_pc.
  - stall[1]=NoStop: deliver in the next cycle and go to REQ.
  - stall[1]=Stop: go to HOLD.
REQ-018 HOLD SHALL keep the buffer and ce=0 while stall[1]=Stop; when stall[1]=NoStop it SHALL deliver and go to REQ.
REQ-019 A delivery SHALL present if_to_id_bus={1,pc} and inst=buffer for exactly one cycle; otherwise ce=0, pc=0 and inst=0.
REQ-020 stallreq SHALL equal (state==REQ)|(state==WAIT); it SHALL be combinational and SHALL be 0 in IDLE and HOLD.
REQ-021 Next fetch_pc at delivery SHALL be redir_valid ? redir_pc : fetch_pc+4, using 32-bit modulo arithmetic (32'hFFFF_FFFC+4 = 0).
REQ-022 br_e=1 SHALL set redir_valid=1 and redir_pc=br_addr in any state; a later br_e SHALL overwrite them.
REQ-023 redir_valid SHALL clear when the redirect is consumed; a simultaneous new br_e SHALL win and leave it set.
REQ-024 The fetch in flight when br_e arrives (the delay slot) SHALL complete and be delivered normally; it SHALL NOT be cancelled.
REQ-025 stall[0]=Stop SHALL block fetch_pc update and the REQ entry from delivery; the FSM SHALL wait in a delivered-idle condition with req=0.
REQ-026 addr_ok and data_ok SHALL be ignored in states where they are not expected; no second request SHALL be outstanding.
REQ-027 A transaction SHALL take at least 3 cycles: REQ, WAIT, then delivery.

Reset
REQ-028 rst low SHALL asynchronously force the following, including mid-transaction:
  - state=IDLE, fetch_pc=RESET_PC;
  - redir_valid=0, redir_pc=0;
  - buffer=0, if_to_id_bus=0, inst=0;
  - req=0, addr=0, stallreq=0.
REQ-029 After reset release, data_ok belonging to a pre-reset request SHALL be discarded.

Structure
REQ-030 StallBus, Stop/NoStop, BR_WD and IF_TO_ID_WD SHALL come from the shared defines header; RESET_PC and the state encodings SHALL be local.
REQ-031 The block SHALL be flat, with no sub-module; the one-entry buffer SHALL be inline registers.

Verification
REQ-032 Reset release with addr_ok and data_ok tied high -> req/addr=BFC00000, then delivery of pc BFC00000, then req with BFC00004.
REQ-033 Hold data_ok low 5 cycles in WAIT -> stallreq=1 for all 5 cycles and ce=0.
  - Then data_ok with rdata=24020001 -> ce=1, inst=24020001.
REQ-034 stall[1]=Stop for 3 cycles at data_ok -> HOLD, ce=0, stallreq=0.
  - On release: one delivery with the original inst; the next addr is +4.
REQ-035 br_e=1 with br_addr=BFC00100 during WAIT for pc BFC00008 -> BFC00008 is delivered.
  - The next request is BFC00100; redir_valid clears.
REQ-036 rst low during WAIT, with a late data_ok after release -> the late data is dropped and the first request is BFC00000.
REQ-037 fetch_pc=FFFFFFFC with no redirect -> the next request address is 00000000.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared pipeline definitions used by the fetch stage and its neighbours.
//   StallBus    : width of the pipeline stall vector (bit0 = PC, bit1 = IF/ID)
//   Stop/NoStop : per-bit stall encodings
//   BR_WD       : width of the decode redirect bus {br_e, br_addr[31:0]}
//   IF_TO_ID_WD : width of the fetch-to-decode bus {ce, pc[31:0]}
package inst_fetch_pkg;

  localparam int   StallBus    = 2;
  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;
  localparam int   BR_WD       = 33;
  localparam int   IF_TO_ID_WD = 33;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage. Issues one request at a time on the instruction
// SRAM handshake, buffers the returned word and delivers {ce, pc} + inst to
// decode for exactly one cycle.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   stall              : bit0 freezes the PC, bit1 freezes the IF/ID boundary
//   br_bus             : {br_e, br_addr} redirect from decode
//   inst_sram_req/addr : fetch request and address (registered)
//   inst_sram_addr_ok  : request accepted
//   inst_sram_data_ok  : read data valid, rdata carries the word
//   if_to_id_bus, inst : delivered {ce, pc} and instruction
//   stallreq           : high while a fetch is outstanding (REQ or WAIT)
//   fsm_state          : current FSM state for observation
// Handshake: a request is accepted in the cycle where req and addr_ok are
// both high; the matching data returns in a later cycle with data_ok high.
// addr_ok is only honoured in REQ and data_ok only in WAIT, so at most one
// request is ever outstanding.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [StallBus-1:0]    stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic                   inst_sram_req,
  output logic [31:0]            inst_sram_addr,
  input  logic                   inst_sram_addr_ok,
  input  logic                   inst_sram_data_ok,
  input  logic [31:0]            inst_sram_rdata,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic [31:0]            inst,
  output logic                   stallreq,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [31:0] buf_inst;
  logic        pc_pending;  // delivered while PC was stalled; advance owed
  logic        out_ce;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  logic        br_e;
  logic [31:0] br_addr;
  logic        deliver_now;
  logic        advance;
  logic [31:0] next_pc;
  logic [31:0] deliver_inst;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];

  always_comb begin
    deliver_now  = 1'b0;
    advance      = 1'b0;
    next_pc      = redir_valid ? redir_pc : fetch_pc + 32'd4;
    deliver_inst = (state == HOLD) ? buf_inst : inst_sram_rdata;
    if (stall[1] == NoStop) begin
      deliver_now = ((state == WAIT) && inst_sram_data_ok) || (state == HOLD);
    end
    // fetch_pc moves either right at delivery or later, once the PC stall lifts
    if (stall[0] == NoStop) begin
      advance = deliver_now || ((state == IDLE) && pc_pending);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      redir_valid    <= 1'b0;
      redir_pc       <= 32'd0;
      buf_inst       <= 32'd0;
      pc_pending     <= 1'b0;
      out_ce         <= 1'b0;
      out_pc         <= 32'd0;
      out_inst       <= 32'd0;
      inst_sram_req  <= 1'b0;
      inst_sram_addr <= 32'd0;
    end else begin
      out_ce   <= 1'b0;
      out_pc   <= 32'd0;
      out_inst <= 32'd0;

      // A new redirect always wins over consumption of the old one.
      if (br_e) begin
        redir_valid <= 1'b1;
        redir_pc    <= br_addr;
      end else if (advance) begin
        redir_valid <= 1'b0;
      end

      if (advance) begin
        fetch_pc <= next_pc;
      end

      case (state)
        IDLE: begin
          if (stall[0] == NoStop) begin
            state          <= REQ;
            inst_sram_req  <= 1'b1;
            inst_sram_addr <= pc_pending ? next_pc : fetch_pc;
            pc_pending     <= 1'b0;
          end
        end
        REQ: begin
          if (inst_sram_addr_ok) begin
            state         <= WAIT;
            inst_sram_req <= 1'b0;
          end
        end
        WAIT: begin
          if (inst_sram_data_ok) begin
            buf_inst <= inst_sram_rdata;
            if (stall[1] == Stop) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          // buffer simply holds while IF/ID is stalled
        end
        default: state <= IDLE;
      endcase

      if (deliver_now) begin
        out_ce   <= 1'b1;
        out_pc   <= fetch_pc;
        out_inst <= deliver_inst;
        if (stall[0] == NoStop) begin
          state          <= REQ;
          inst_sram_req  <= 1'b1;
          inst_sram_addr <= next_pc;
        end else begin
          state      <= IDLE;
          pc_pending <= 1'b1;
        end
      end
    end
  end

  assign stallreq     = (state == REQ) || (state == WAIT);
  assign if_to_id_bus = {out_ce, out_pc};
  assign inst         = out_inst;
  assign fsm_state    = state;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: inputs change on the falling edge, outputs
// are checked on the following falling edge.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic                   clk;
  logic                   rst;
  logic [StallBus-1:0]    stall;
  logic [BR_WD-1:0]       br_bus;
  logic                   inst_sram_req;
  logic [31:0]            inst_sram_addr;
  logic                   inst_sram_addr_ok;
  logic                   inst_sram_data_ok;
  logic [31:0]            inst_sram_rdata;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;
  logic [31:0]            inst;
  logic                   stallreq;
  logic [1:0]             fsm_state;

  int checks;
  int failures;
  logic [31:0] exp_q[$];  // expected delivered pc values, in order

  inst_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .br_bus           (br_bus),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata),
    .if_to_id_bus     (if_to_id_bus),
    .inst             (inst),
    .stallreq         (stallreq),
    .fsm_state        (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver tasks
  task automatic drive(input logic aok, input logic dok, input logic [31:0] rd);
    inst_sram_addr_ok = aok;
    inst_sram_data_ok = dok;
    inst_sram_rdata   = rd;
  endtask

  task automatic check_idle_bus(input string tag);
    check_val({tag, "_ce"}, 32'(if_to_id_bus[32]), 32'd0);
    check_val({tag, "_pc"}, if_to_id_bus[31:0], 32'd0);
    check_val({tag, "_inst"}, inst, 32'd0);
  endtask

  task automatic check_req(input string tag, input logic r, input logic [31:0] a);
    check_val({tag, "_req"}, 32'(inst_sram_req), 32'(r));
    if (r) check_val({tag, "_addr"}, inst_sram_addr, a);
  endtask

  // scoreboard: a delivery must carry the pc at the head of exp_q
  task automatic check_delivery(input string tag, input logic [31:0] exp_inst);
    logic [31:0] exp_pc;
    exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check_val({tag, "_ce"}, 32'(if_to_id_bus[32]), 32'd1);
    check_val({tag, "_pc"}, if_to_id_bus[31:0], exp_pc);
    check_val({tag, "_inst"}, inst, exp_inst);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    stall    = '0;
    br_bus   = '0;
    drive(1'b0, 1'b0, 32'd0);
    repeat (2) tick();

    // reset state
    check_req("rst", 1'b0, 32'd0);
    check_val("rst_addr", inst_sram_addr, 32'd0);
    check_val("rst_stallreq", 32'(stallreq), 32'd0);
    check_val("rst_state", 32'(fsm_state), 32'd0);
    check_idle_bus("rst");

    // first fetch with addr_ok/data_ok tied high
    drive(1'b1, 1'b1, 32'h1111_0000);
    rst = 1'b1;
    tick();
    check_req("first_req", 1'b1, 32'hBFC0_0000);
    check_val("first_stallreq", 32'(stallreq), 32'd1);
    check_idle_bus("first_req");
    tick();
    check_val("first_wait_req", 32'(inst_sram_req), 32'd0);
    check_val("first_wait_state", 32'(fsm_state), 32'd2);
    exp_q.push_back(32'hBFC0_0000);
    tick();
    check_delivery("first_dlv", 32'h1111_0000);
    check_req("second_req", 1'b1, 32'hBFC0_0004);

    // data_ok held low for five WAIT cycles
    drive(1'b1, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("slow_stallreq%0d", i), 32'(stallreq), 32'd1);
      check_val($sformatf("slow_ce%0d", i), 32'(if_to_id_bus[32]), 32'd0);
      tick();
    end
    drive(1'b0, 1'b1, 32'h2402_0001);
    exp_q.push_back(32'hBFC0_0004);
    tick();
    check_delivery("slow_dlv", 32'h2402_0001);
    check_req("slow_next", 1'b1, 32'hBFC0_0008);

    // redirect during WAIT: delay slot still delivered
    drive(1'b1, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    br_bus = {1'b1, 32'hBFC0_0100};
    tick();
    br_bus = '0;
    drive(1'b0, 1'b1, 32'h3333_0008);
    exp_q.push_back(32'hBFC0_0008);
    tick();
    check_delivery("slot_dlv", 32'h3333_0008);
    check_req("redir_req", 1'b1, 32'hBFC0_0100);
    drive(1'b1, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b1, 32'h3333_0100);
    exp_q.push_back(32'hBFC0_0100);
    tick();
    check_delivery("redir_dlv", 32'h3333_0100);
    check_req("redir_cleared", 1'b1, 32'hBFC0_0104);

    // IF/ID stall at data_ok -> HOLD for three cycles
    drive(1'b1, 1'b0, 32'd0);
    tick();
    stall = 2'b10;
    drive(1'b0, 1'b1, 32'h4444_0104);
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b0, 1'b0, 32'hDEAD_BEEF);
      check_val($sformatf("hold_state%0d", i), 32'(fsm_state), 32'd3);
      check_val($sformatf("hold_stallreq%0d", i), 32'(stallreq), 32'd0);
      check_val($sformatf("hold_ce%0d", i), 32'(if_to_id_bus[32]), 32'd0);
    end
    stall = 2'b00;
    exp_q.push_back(32'hBFC0_0104);
    tick();
    check_delivery("hold_dlv", 32'h4444_0104);
    check_req("hold_next", 1'b1, 32'hBFC0_0108);
    tick();
    check_val("hold_single_ce", 32'(if_to_id_bus[32]), 32'd0);

    // PC stall at delivery: wait with req low, then resume at +4
    drive(1'b1, 1'b0, 32'd0);
    tick();
    stall = 2'b01;
    drive(1'b0, 1'b1, 32'h5555_0108);
    exp_q.push_back(32'hBFC0_0108);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    check_delivery("pcstall_dlv", 32'h5555_0108);
    check_val("pcstall_req", 32'(inst_sram_req), 32'd0);
    check_val("pcstall_stallreq", 32'(stallreq), 32'd0);
    tick();
    check_val("pcstall_wait_req", 32'(inst_sram_req), 32'd0);
    stall = 2'b00;
    tick();
    check_req("pcstall_resume", 1'b1, 32'hBFC0_010C);

    // reset during WAIT, late data_ok after release is dropped
    drive(1'b1, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    check_val("mid_wait_state", 32'(fsm_state), 32'd2);
    rst = 1'b0;
    #1;
    check_val("async_rst_state", 32'(fsm_state), 32'd0);
    check_val("async_rst_req", 32'(inst_sram_req), 32'd0);
    check_val("async_rst_stallreq", 32'(stallreq), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'hBAD0_BAD0);
    tick();
    check_req("post_rst_req", 1'b1, 32'hBFC0_0000);
    check_val("post_rst_ce", 32'(if_to_id_bus[32]), 32'd0);
    tick();
    check_val("late_data_state", 32'(fsm_state), 32'd1);
    check_idle_bus("late_data");

    // wrap: redirect to FFFFFFFC, next sequential address is 0
    drive(1'b1, 1'b0, 32'd0);
    br_bus = {1'b1, 32'hFFFF_FFFC};
    tick();
    br_bus = '0;
    drive(1'b0, 1'b1, 32'h6666_0000);
    exp_q.push_back(32'hBFC0_0000);
    tick();
    check_delivery("wrap_pre_dlv", 32'h6666_0000);
    check_req("wrap_top_req", 1'b1, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b1, 32'h7777_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    check_delivery("wrap_dlv", 32'h7777_FFFC);
    check_req("wrap_req", 1'b1, 32'h0000_0000);

    check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
